warp_issue_scheduler: RTL and testbench
=======================================

WARP_ISSUE_SCHEDULER -- requirements
Module: warp_issue_scheduler

Interface
REQ-001 Parameters SHALL be:
- NUM_WARPS, default 8, number of per-warp instruction buffers.
- ARCH_LEN, default 32, PC width.
- OP_BITS, default 7, opcode width.
- REG_BITS, default 8, destination register width.
- MAX_INFLIGHT, default 4, maximum outstanding writebacks per warp.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; leaves IDLE.
- ibuf_valid  in  NUM_WARPS  per-warp instruction available.
- ibuf_pc  in  ARCH_LEN*NUM_WARPS  packed per-warp PC; warp w at [ARCH_LEN*w +: ARCH_LEN].
- ibuf_op  in  OP_BITS*NUM_WARPS  packed per-warp opcode.
- ibuf_rd  in  REG_BITS*NUM_WARPS  packed per-warp destination register.
- ibuf_ready  out  NUM_WARPS  per-warp dequeue, one-hot or zero.
- finished  in  1  level; instruction source exhausted.
- issue_valid  out  1  issue register holds an instruction.
- issue_ready  in  1  downstream accepts.
- issue_warp  out  clog2(NUM_WARPS)  warp of the issued instruction.
- issue_pc  out  ARCH_LEN  PC of the issued instruction.
- issue_op  out  OP_BITS  opcode of the issued instruction.
- issue_rd  out  REG_BITS  destination register of the issued instruction.
- wb_valid  in  1  writeback completion.
- wb_warp  in  clog2(NUM_WARPS)  warp of the writeback.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- wb_underflow  out  1  sticky error flag.

Function
REQ-003 States SHALL be IDLE, RUN, DRAIN, DONE, with these transitions:
- IDLE->RUN on start.
- RUN->DRAIN when finished=1.
- DRAIN->DONE when issue_valid=0 and all inflight counters are 0.
- DONE->RUN on start; the inflight counters SHALL NOT be cleared by this transition.
REQ-004 Each warp SHALL have a counter inflight[w] of width clog2(MAX_INFLIGHT+1).
REQ-005 Warp w SHALL be eligible when state=RUN, ibuf_valid[w]=1 and inflight[w]<MAX_INFLIGHT.
REQ-006 The issue register SHALL be able to load when issue_valid=0 or issue_ready=1.
REQ-007 When the issue register can load, exactly one eligible warp SHALL be granted, chosen round-robin starting at (rr_ptr+1) mod NUM_WARPS; rr_ptr SHALL update to the granted warp.
REQ-008 ibuf_ready[w] SHALL be 1 only for the granted warp, in the same cycle as the grant, combinationally from current inputs and state.
REQ-009 On a grant, the issue register SHALL capture warp, pc, op and rd on the next edge and set issue_valid=1; latency from ibuf handshake to issue_valid is 1 cycle.
REQ-010 Without a grant, issue_valid SHALL clear on issue_ready=1 and SHALL otherwise hold with all payload unchanged (no-drop, stable-while-stalled).
REQ-011 A grant with rd!=0 SHALL increment inflight[w]; rd==0 SHALL NOT increment.
REQ-012 wb_valid SHALL decrement inflight[wb_warp].
REQ-013 An issue and a writeback to the same warp in the same cycle SHALL leave the counter unchanged.
REQ-014 A writeback to a warp whose counter is 0 SHALL leave the counter at 0 and set wb_underflow, which SHALL hold until reset.
REQ-015 Writebacks SHALL be processed in every state.
REQ-016 In DRAIN, IDLE and DONE no grants SHALL occur; a held issue register SHALL still complete on issue_ready.
REQ-017 If finished rises in the same cycle as a grant, the grant SHALL proceed and the state SHALL enter DRAIN.
REQ-018 start SHALL be ignored in RUN and DRAIN.

Reset
REQ-019 While reset_n=0, regardless of clock, the following SHALL hold:
- state=IDLE.
- issue_valid=0; issue payload fields 0.
- all inflight=0.
- rr_ptr=NUM_WARPS-1, so the first grant favours warp 0.
- wb_underflow=0.
- ibuf_ready=0, busy=0, done=0.
REQ-020 Deassertion of reset_n SHALL take effect on the next rising edge; reset asserted mid-operation SHALL discard the held instruction and all counters.

Verification
REQ-021 After start, all 8 ibuf_valid=1 with rd=5 and issue_ready=1 -> grants to warps 0,1,...,7,0 on consecutive cycles; issue_warp lags each grant by 1 cycle.
REQ-022 Warp 2 only valid, no writebacks, rd=3 -> exactly 4 issues, then ibuf_ready[2]=0; one wb_valid with wb_warp=2 -> a 5th issue the following cycle.
REQ-023 issue_ready=0 for 5 cycles while issue_valid=1 -> payload stable, ibuf_ready=0 throughout; then issue_ready=1 -> accepted, next grant the same cycle.
REQ-024 Same-cycle issue and writeback on warp 1 with inflight=2 -> inflight stays 2; wb_valid to warp 4 with inflight=0 -> wb_underflow=1, counter stays 0.
REQ-025 finished=1 with 3 outstanding writebacks -> DRAIN, busy=1, no grants; after the 3rd wb -> done=1 the next cycle.
REQ-026 reset_n pulsed low mid-RUN with issue_valid=1 -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler with a single-entry issue register and
// per-warp outstanding-writeback counters gating eligibility.
module warp_issue_scheduler #(
    parameter int NUM_WARPS    = 8,
    parameter int ARCH_LEN     = 32,
    parameter int OP_BITS      = 7,
    parameter int REG_BITS     = 8,
    parameter int MAX_INFLIGHT = 4,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NUM_WARPS-1:0]          ibuf_valid,
    input  logic [ARCH_LEN*NUM_WARPS-1:0] ibuf_pc,
    input  logic [OP_BITS*NUM_WARPS-1:0]  ibuf_op,
    input  logic [REG_BITS*NUM_WARPS-1:0] ibuf_rd,
    output logic [NUM_WARPS-1:0]          ibuf_ready,
    input  logic                          finished,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [WW-1:0]                 issue_warp,
    output logic [ARCH_LEN-1:0]           issue_pc,
    output logic [OP_BITS-1:0]            issue_op,
    output logic [REG_BITS-1:0]           issue_rd,
    input  logic                          wb_valid,
    input  logic [WW-1:0]                 wb_warp,
    output logic                          busy,
    output logic                          done,
    output logic                          wb_underflow
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state, state_nxt;
    logic [WW-1:0]                rr_ptr, grant_idx;
    logic [NUM_WARPS-1:0]         eligible, grant, wb_uf;
    logic [NUM_WARPS-1:0][CW-1:0] inflight;
    logic                         can_load, any_grant;
    logic [REG_BITS-1:0]          sel_rd;

    assign can_load = !issue_valid || issue_ready;

    // Search starts one past the last winner so every warp gets a turn.
    always_comb begin
        any_grant = 1'b0;
        grant_idx = rr_ptr;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            if (!any_grant && can_load && eligible[(int'(rr_ptr) + i) % NUM_WARPS]) begin
                any_grant = 1'b1;
                grant_idx = WW'((int'(rr_ptr) + i) % NUM_WARPS);
            end
        end
        grant = any_grant ? (NUM_WARPS'(1) << grant_idx) : '0;
    end

    assign sel_rd     = ibuf_rd[REG_BITS*grant_idx +: REG_BITS];
    assign ibuf_ready = grant;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [CW-1:0] cnt;
        logic          inc, dec;

        assign inc         = grant[w] && (sel_rd != '0);
        assign dec         = wb_valid && (wb_warp == WW'(w));
        assign eligible[w] = (state == RUN) && ibuf_valid[w] && (cnt < CW'(MAX_INFLIGHT));
        assign wb_uf[w]    = dec && !inc && (cnt == '0);
        assign inflight[w] = cnt;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                cnt <= '0;
            else if (inc && !dec)
                cnt <= cnt + 1'b1;
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finished) state_nxt = DRAIN;
            DRAIN:   if (!issue_valid && inflight == '0) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rr_ptr       <= WW'(NUM_WARPS - 1);
            wb_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (any_grant) rr_ptr <= grant_idx;
            if (|wb_uf) wb_underflow <= 1'b1;
        end
    end

    // Payload is only written on a grant, so a stalled entry never changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid <= 1'b0;
            issue_warp  <= '0;
            issue_pc    <= '0;
            issue_op    <= '0;
            issue_rd    <= '0;
        end else if (any_grant) begin
            issue_valid <= 1'b1;
            issue_warp  <= grant_idx;
            issue_pc    <= ibuf_pc[ARCH_LEN*grant_idx +: ARCH_LEN];
            issue_op    <= ibuf_op[OP_BITS*grant_idx +: OP_BITS];
            issue_rd    <= sel_rd;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench: grants are checked as they happen and queued; a negedge
// monitor pops the queue on every issue handshake and compares the payload.
module tb_warp_issue_scheduler;

    logic         clock = 1'b0;
    logic         reset_n, start, finished, issue_ready, wb_valid;
    logic [7:0]   ibuf_valid, ibuf_ready;
    logic [255:0] ibuf_pc;
    logic [55:0]  ibuf_op;
    logic [63:0]  ibuf_rd;
    logic [2:0]   wb_warp, issue_warp;
    logic         issue_valid, busy, done, wb_underflow;
    logic [31:0]  issue_pc;
    logic [6:0]   issue_op;
    logic [7:0]   issue_rd;

    typedef struct packed {
        logic [2:0]  warp;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [7:0]  rd;
    } rec_t;

    rec_t       sb[$];
    logic [7:0] cur_rd;
    int         tests = 0, fails = 0;

    warp_issue_scheduler dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .ibuf_valid(ibuf_valid), .ibuf_pc(ibuf_pc), .ibuf_op(ibuf_op), .ibuf_rd(ibuf_rd),
        .ibuf_ready(ibuf_ready), .finished(finished),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_warp(issue_warp),
        .issue_pc(issue_pc), .issue_op(issue_op), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_warp(wb_warp),
        .busy(busy), .done(done), .wb_underflow(wb_underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic neg; @(negedge clock); endtask
    task automatic nxt; @(posedge clock); #1; endtask

    task automatic set_rd(input logic [7:0] r);
        cur_rd = r;
        for (int w = 0; w < 8; w++) ibuf_rd[8*w +: 8] = r;
    endtask

    task automatic expect_grant(input int w);
        rec_t r;
        chk("grant", 64'(ibuf_ready), 64'(1) << w);
        r.warp = 3'(w);
        r.pc   = 32'(256 * (w + 1));
        r.op   = 7'(w + 1);
        r.rd   = cur_rd;
        sb.push_back(r);
    endtask

    task automatic do_reset_start(input logic leftovers_ok);
        reset_n = 1'b0; start = 1'b0; ibuf_valid = '0; issue_ready = 1'b0;
        wb_valid = 1'b0; wb_warp = '0; finished = 1'b0;
        if (!leftovers_ok) chk("sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();
        nxt; reset_n = 1'b1;
        nxt; start = 1'b1;
        nxt; start = 1'b0;
    endtask

    // Every accepted issue must match the oldest expected grant.
    always @(negedge clock) begin
        if (reset_n && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", 64'({issue_warp, issue_pc, issue_op, issue_rd}), 64'd0);
            end else begin
                rec_t e;
                e = sb.pop_front();
                chk("issue_payload", 64'({issue_warp, issue_pc, issue_op, issue_rd}), 64'(e));
            end
        end
    end

    initial begin
        for (int w = 0; w < 8; w++) begin
            ibuf_pc[32*w +: 32] = 32'(256 * (w + 1));
            ibuf_op[7*w +: 7]   = 7'(w + 1);
        end
        set_rd(8'd0);
        reset_n = 1'b0; start = 1'b0; ibuf_valid = '0; issue_ready = 1'b0;
        wb_valid = 1'b0; wb_warp = '0; finished = 1'b0;

        // Reset values before any clock edge
        #3;
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_ibuf_ready", 64'(ibuf_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_underflow", 64'(wb_underflow), 64'd0);
        chk("rst_pc", 64'(issue_pc), 64'd0);

        // Round robin across all warps, issue_warp one cycle behind the grant
        do_reset_start(1'b0);
        set_rd(8'd5); ibuf_valid = 8'hFF; issue_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            neg; expect_grant(k % 8);
            if (k > 0) chk("issue_lag", 64'(issue_warp), 64'((k - 1) % 8));
            nxt;
        end
        ibuf_valid = '0;
        neg; chk("rr_idle", 64'(ibuf_ready), 64'd0); chk("rr_last_warp", 64'(issue_warp), 64'd0); nxt;
        neg; chk("rr_drained", 64'(issue_valid), 64'd0); nxt;

        // Inflight limit on warp 2, released by one writeback
        do_reset_start(1'b0);
        set_rd(8'd3); ibuf_valid = 8'h04; issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin neg; expect_grant(2); nxt; end
        for (int k = 0; k < 2; k++) begin neg; chk("limit_block", 64'(ibuf_ready), 64'd0); nxt; end
        wb_valid = 1'b1; wb_warp = 3'd2;
        neg; chk("limit_wb_cycle", 64'(ibuf_ready), 64'd0); nxt;
        wb_valid = 1'b0;
        neg; expect_grant(2); chk("limit_no_uf", 64'(wb_underflow), 64'd0); nxt;
        ibuf_valid = '0; nxt;

        // Stall: payload stable, no grants, then accept and grant same cycle
        do_reset_start(1'b0);
        set_rd(8'd0); ibuf_valid = 8'h03; issue_ready = 1'b1;
        neg; expect_grant(0); nxt;
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            neg;
            chk("stall_ready", 64'(ibuf_ready), 64'd0);
            chk("stall_valid", 64'(issue_valid), 64'd1);
            chk("stall_pc", 64'(issue_pc), 64'h100);
            chk("stall_op", 64'(issue_op), 64'd1);
            nxt;
        end
        issue_ready = 1'b1;
        neg; expect_grant(1); nxt;
        neg; expect_grant(0); nxt;
        ibuf_valid = '0; nxt;

        // Same-cycle issue+writeback keeps count; underflow is sticky, count stays 0
        do_reset_start(1'b0);
        set_rd(8'd7); ibuf_valid = 8'h02; issue_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin neg; expect_grant(1); nxt; end
        wb_valid = 1'b1; wb_warp = 3'd1;
        neg; expect_grant(1); nxt;
        wb_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin neg; expect_grant(1); nxt; end
        neg; chk("same_cycle_limit", 64'(ibuf_ready), 64'd0); nxt;
        ibuf_valid = '0; wb_valid = 1'b1; wb_warp = 3'd4;
        neg; chk("uf_before", 64'(wb_underflow), 64'd0); nxt;
        wb_valid = 1'b0;
        neg; chk("uf_set", 64'(wb_underflow), 64'd1); nxt;
        ibuf_valid = 8'h10;
        for (int k = 0; k < 4; k++) begin neg; expect_grant(4); nxt; end
        neg; chk("uf_cnt_zero", 64'(ibuf_ready), 64'd0); chk("uf_sticky", 64'(wb_underflow), 64'd1); nxt;
        ibuf_valid = '0; nxt;

        // finished alongside a grant, drain 3 writebacks, then DONE
        do_reset_start(1'b0);
        set_rd(8'd1); ibuf_valid = 8'h07; issue_ready = 1'b1;
        neg; expect_grant(0); nxt;
        neg; expect_grant(1); nxt;
        finished = 1'b1;
        neg; expect_grant(2); nxt;
        neg;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_nogrant", 64'(ibuf_ready), 64'd0);
        chk("drain_done", 64'(done), 64'd0);
        nxt;
        for (int w = 0; w < 3; w++) begin
            wb_valid = 1'b1; wb_warp = 3'(w);
            neg; chk("drain_wait", 64'(done), 64'd0); chk("drain_nogrant2", 64'(ibuf_ready), 64'd0); nxt;
        end
        wb_valid = 1'b0; finished = 1'b0;
        nxt;
        neg; chk("done_set", 64'(done), 64'd1); chk("done_busy", 64'(busy), 64'd0); nxt;

        // Asynchronous reset while an instruction is held
        do_reset_start(1'b0);
        set_rd(8'd2); ibuf_valid = 8'h01; issue_ready = 1'b0;
        neg; expect_grant(0); nxt;
        ibuf_valid = '0;
        neg; chk("held_valid", 64'(issue_valid), 64'd1); chk("held_busy", 64'(busy), 64'd1);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 64'(issue_valid), 64'd0);
        chk("async_pc", 64'(issue_pc), 64'd0);
        chk("async_rd", 64'(issue_rd), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_ready", 64'(ibuf_ready), 64'd0);
        sb.delete();
        #10;
        reset_n = 1'b1;
        nxt; nxt;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
